cycle_controller: RTL and testbench
===================================

Name: cycle_controller

Overview:
- Multi-cycle control FSM that sequences the processor datapath through fetch, decode, execute, memory and writeback.
- Decodes the IR opcode field and drives the strobes for the IR, PC, register file, data memory and the EPC/Cause system registers.
- Handles a variable-latency data-memory handshake with a timeout.
- Raises the program-finished "signal" to the test bench on HALT.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles a data-memory access may wait for mem_ready before faulting (1..255).
- HALT_OPCODE, 6'h3F, opcode that terminates the program.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears the FSM on the next rising edge of clk.
- start  input  1  level; begins execution from IDLE.
- ir_opcode  input  6  IR[31:26], valid from DECODE onward.
- ir_funct  input  6  IR[5:0]; any value is accepted for R-type.
- alu_zero  input  1  ALU zero flag, valid in EXEC.
- alu_ovf  input  1  ALU signed-overflow flag, valid in EXEC.
- mem_ready  input  1  data-memory access complete.
- ir_load  output  1  load IR from instruction memory at PC.
- pc_we  output  1  write PC.
- pc_sel  output  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target.
- alu_src_imm  output  1  ALU operand B is the sign-extended immediate.
- rf_we  output  1  register-file write (r0 write is suppressed by the datapath).
- wb_sel  output  1  writeback source: 0 = ALU result, 1 = memory data.
- mem_rd  output  1  data-memory read request.
- mem_wr  output  1  data-memory write request.
- epc_we  output  1  write EPC with the faulting instruction address (PC-1).
- cause_we  output  1  write the Cause register.
- cause_code  output  5  exception code.
- signal  output  1  program finished; sticky.
- state_o  output  3  current state, for debug.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, EXC=6, HALT=7.
- Reset: state goes to IDLE, the timer clears, and every output is 0 (pc_sel=0, cause_code=0, signal=0). Reset mid-operation aborts any access; strobes are low from the next cycle.
- Output style: all outputs are Moore functions of the state, except pc_we in EXEC (depends on alu_zero) and the cause outputs in EXC (depend on the latched cause).
- IDLE: stays in IDLE while start=0; start=1 moves to FETCH.
- FETCH: ir_load=1, pc_we=1, pc_sel=0. Always moves to DECODE.
- DECODE, selected by ir_opcode:
  - 6'h00 (R-type), 6'h08 (ADDI), 6'h23 (LW), 6'h2B (SW), 6'h04 (BEQ): move to EXEC.
  - 6'h02 (J): pc_we=1, pc_sel=2, then FETCH.
  - HALT_OPCODE: move to HALT.
  - Any other opcode: latch cause 10 (reserved instruction) and move to EXC.
- EXEC:
  - alu_src_imm=1 for ADDI, LW and SW.
  - R-type/ADDI: alu_ovf=1 latches cause 12 and moves to EXC; otherwise moves to WB.
  - LW/SW: move to MEM.
  - BEQ: pc_we=alu_zero, pc_sel=1, then FETCH.
- MEM:
  - mem_rd (LW) or mem_wr (SW) is held high each cycle until mem_ready=1. The request may be accepted in the same cycle it is raised.
  - On ready, LW moves to WB and SW moves to FETCH.
  - The wait counter increments each cycle mem_ready=0. On reaching MEM_TIMEOUT, the controller latches cause 4 (LW) or 5 (SW) and moves to EXC; strobes drop in EXC.
  - The counter clears on leaving MEM.
- WB: rf_we=1, wb_sel=1 for LW and 0 otherwise. Moves to FETCH.
- EXC: epc_we=1, cause_we=1, cause_code=latched cause, held for exactly one cycle. Moves to HALT.
- HALT: signal=1, all other strobes 0. Stays in HALT until reset; start is ignored.
- Cycle counts:
  - R-type/ADDI: 4 cycles.
  - LW: 5+w cycles, where w = cycles with mem_ready low.
  - SW: 4+w cycles.
  - BEQ: 3 cycles.
  - J: 2 cycles.
- Simultaneous events:
  - reset has priority over everything.
  - alu_ovf is ignored for LW, SW and BEQ.
  - mem_ready outside MEM is ignored.

Decomposition:
- Shared package proc_ctrl_pkg:
  - state encoding;
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT);
  - cause codes (CAUSE_ADEL=4, CAUSE_ADES=5, CAUSE_RI=10, CAUSE_OV=12);
  - pc_sel encodings.
- One sub-module: mem_wait_timer (clear, count-enable, expired flag, parameterised by MEM_TIMEOUT).

Test Plan:
- Reset with start=1, then ADDI (opcode 6'h08) with ovf=0 → states 1,2,3,5; rf_we high only in cycle 4; ir_load and pc_we high in cycle 1.
- LW with mem_ready low for 3 cycles → mem_rd high for exactly 4 cycles, then WB with wb_sel=1; total 8 cycles.
- BEQ with alu_zero=1, then with alu_zero=0 → pc_we=1 and pc_sel=1 in EXEC for the first; pc_we=0 in EXEC for the second; both return to FETCH after 3 cycles.
- SW with mem_ready held low (MEM_TIMEOUT=15) → mem_wr high for 15 cycles, then EXC with cause_code=5 and epc_we=1 for one cycle, then HALT with signal=1.
- Opcode 6'h11, and separately R-type with alu_ovf=1 → EXC with cause_code=10 and 12 respectively; HALT opcode 6'h3F → HALT directly, signal=1 stays high for 20 cycles with start toggling.
- Reset asserted mid-MEM (mem_rd=1) → the next cycle shows state_o=0, mem_rd=0 and signal=0.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared encodings for the multi-cycle processor controller
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_EXC    = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;
  localparam logic [4:0] CAUSE_RI   = 5'd10;
  localparam logic [4:0] CAUSE_OV   = 5'd12;

  localparam logic [1:0] PC_SEL_INC    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  function automatic logic uses_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts data-memory wait cycles and flags the timeout
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count;

  // expired marks the wait cycle whose increment would reach MEM_TIMEOUT
  assign expired = count_en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/cycle_controller.sv
// rtl/cycle_controller.sv - fetch/decode/execute/memory/writeback sequencing FSM
module cycle_controller
  import proc_ctrl_pkg::*;
#(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [5:0] HALT_OPCODE = OP_HALT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] ir_opcode,
  input  logic [5:0] ir_funct,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_src_imm,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       epc_we,
  output logic       cause_we,
  output logic [4:0] cause_code,
  output logic       signal,
  output logic [2:0] state_o
);

  state_t     state, next_state;
  logic [4:0] cause_q, cause_d;
  logic       timer_expired;
  logic       is_lw;
  logic       unused_funct;

  assign unused_funct = ^ir_funct;
  assign is_lw        = (ir_opcode == OP_LW);
  assign state_o      = state;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != S_MEM),
    .count_en ((state == S_MEM) && !mem_ready),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cause_q <= '0;
    end else begin
      state   <= next_state;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    next_state  = state;
    cause_d     = cause_q;
    ir_load     = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_SEL_INC;
    alu_src_imm = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    epc_we      = 1'b0;
    cause_we    = 1'b0;
    cause_code  = '0;
    signal      = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_FETCH;
      S_FETCH: begin
        ir_load    = 1'b1;
        pc_we      = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        if (ir_opcode == HALT_OPCODE) begin
          next_state = S_HALT;
        end else begin
          case (ir_opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: next_state = S_EXEC;
            OP_J: begin
              pc_we      = 1'b1;
              pc_sel     = PC_SEL_JUMP;
              next_state = S_FETCH;
            end
            default: begin
              cause_d    = CAUSE_RI;
              next_state = S_EXC;
            end
          endcase
        end
      end
      S_EXEC: begin
        alu_src_imm = uses_imm(ir_opcode);
        case (ir_opcode)
          OP_RTYPE, OP_ADDI: begin
            if (alu_ovf) begin
              cause_d    = CAUSE_OV;
              next_state = S_EXC;
            end else begin
              next_state = S_WB;
            end
          end
          OP_LW, OP_SW: next_state = S_MEM;
          OP_BEQ: begin
            pc_we      = alu_zero;
            pc_sel     = PC_SEL_BRANCH;
            next_state = S_FETCH;
          end
          default: begin
            cause_d    = CAUSE_RI;
            next_state = S_EXC;
          end
        endcase
      end
      S_MEM: begin
        mem_rd = is_lw;
        mem_wr = !is_lw;
        if (mem_ready) begin
          next_state = is_lw ? S_WB : S_FETCH;
        end else if (timer_expired) begin
          cause_d    = is_lw ? CAUSE_ADEL : CAUSE_ADES;
          next_state = S_EXC;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        wb_sel     = is_lw;
        next_state = S_FETCH;
      end
      S_EXC: begin
        epc_we     = 1'b1;
        cause_we   = 1'b1;
        cause_code = cause_q;
        next_state = S_HALT;
      end
      S_HALT: signal = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cycle_controller.sv
// tb/tb_cycle_controller.sv - directed self-checking bench for cycle_controller
module tb_cycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] ir_opcode = 6'h00;
  logic [5:0] ir_funct = 6'h20;
  logic       alu_zero = 1'b0;
  logic       alu_ovf = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_load, pc_we, alu_src_imm, rf_we, wb_sel, mem_rd, mem_wr;
  logic       epc_we, cause_we, signal;
  logic [1:0] pc_sel;
  logic [4:0] cause_code;
  logic [2:0] state_o;
  logic [16:0] outs;

  int total = 0;
  int bad = 0;

  logic [2:0]  q_st[$];
  logic [16:0] q_o[$];
  logic [2:0]  q_in[$];

  cycle_controller #(.MEM_TIMEOUT(15), .HALT_OPCODE(6'h3F)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ir_opcode   (ir_opcode),
    .ir_funct    (ir_funct),
    .alu_zero    (alu_zero),
    .alu_ovf     (alu_ovf),
    .mem_ready   (mem_ready),
    .ir_load     (ir_load),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .alu_src_imm (alu_src_imm),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .epc_we      (epc_we),
    .cause_we    (cause_we),
    .cause_code  (cause_code),
    .signal      (signal),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  assign outs = {ir_load, pc_we, pc_sel, alu_src_imm, rf_we, wb_sel,
                 mem_rd, mem_wr, epc_we, cause_we, cause_code, signal};

  function automatic logic [16:0] mk(input logic il, input logic pw, input logic [1:0] ps,
                                     input logic imm, input logic rf, input logic wb,
                                     input logic rd, input logic wr, input logic ep,
                                     input logic cw, input logic [4:0] cc, input logic sg);
    return {il, pw, ps, imm, rf, wb, rd, wr, ep, cw, cc, sg};
  endfunction

  localparam logic [16:0] O_Z      = 17'h0;
  localparam logic [16:0] O_FETCH  = {1'b1, 1'b1, 15'h0};
  localparam logic [16:0] O_IMM    = {4'b0, 1'b1, 12'h0};
  localparam logic [16:0] O_WB_ALU = {5'b0, 1'b1, 11'h0};
  localparam logic [16:0] O_WB_MEM = {5'b0, 2'b11, 10'h0};
  localparam logic [16:0] O_RD     = {7'b0, 1'b1, 9'h0};
  localparam logic [16:0] O_WR     = {8'b0, 1'b1, 8'h0};
  localparam logic [16:0] O_HALT   = 17'h1;

  task automatic add(input logic [2:0] st, input logic [16:0] o, input logic [2:0] in_bits);
    q_st.push_back(st);
    q_o.push_back(o);
    q_in.push_back(in_bits);
  endtask

  task automatic clear_q();
    q_st.delete();
    q_o.delete();
    q_in.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    {mem_ready, alu_zero, alu_ovf} = 3'b000;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    total++;
    if (state_o !== 3'd0) begin $display("FAIL reset_state: got %0d want 0", state_o); bad++; end
    total++;
    if (outs !== O_Z) begin $display("FAIL reset_outs: got %h want %h", outs, O_Z); bad++; end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (state_o !== 3'd0) begin $display("FAIL idle_hold: got %0d want 0", state_o); bad++; end
  endtask

  task automatic test_addi();
    do_reset();
    start = 1'b1;
    ir_opcode = 6'h08;
    clear_q();
    add(0, O_Z, 3'b000); add(1, O_FETCH, 3'b000); add(2, O_Z, 3'b000);
    add(3, O_IMM, 3'b000); add(5, O_WB_ALU, 3'b000); add(1, O_FETCH, 3'b000);
    for (int i = 0; i < q_st.size(); i++) begin
      {mem_ready, alu_zero, alu_ovf} = q_in[i];
      #1;
      total++;
      if (state_o !== q_st[i] || outs !== q_o[i]) begin
        $display("FAIL addi[%0d]: state=%0d outs=%h want state=%0d outs=%h", i, state_o, outs, q_st[i], q_o[i]);
        bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    start = 1'b1;
    ir_opcode = 6'h23;
    clear_q();
    add(0, O_Z, 3'b000); add(1, O_FETCH, 3'b000); add(2, O_Z, 3'b100);
    add(3, O_IMM, 3'b001);
    add(4, O_RD, 3'b000); add(4, O_RD, 3'b000); add(4, O_RD, 3'b000); add(4, O_RD, 3'b100);
    add(5, O_WB_MEM, 3'b000); add(1, O_FETCH, 3'b000);
    for (int i = 0; i < q_st.size(); i++) begin
      {mem_ready, alu_zero, alu_ovf} = q_in[i];
      #1;
      total++;
      if (state_o !== q_st[i] || outs !== q_o[i]) begin
        $display("FAIL lw[%0d]: state=%0d outs=%h want state=%0d outs=%h", i, state_o, outs, q_st[i], q_o[i]);
        bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    do_reset();
    start = 1'b1;
    ir_opcode = 6'h04;
    clear_q();
    add(0, O_Z, 3'b000); add(1, O_FETCH, 3'b000); add(2, O_Z, 3'b000);
    add(3, mk(0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0), 3'b011);
    add(1, O_FETCH, 3'b000); add(2, O_Z, 3'b000);
    add(3, mk(0, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0), 3'b001);
    add(1, O_FETCH, 3'b000);
    for (int i = 0; i < q_st.size(); i++) begin
      {mem_ready, alu_zero, alu_ovf} = q_in[i];
      #1;
      total++;
      if (state_o !== q_st[i] || outs !== q_o[i]) begin
        $display("FAIL beq[%0d]: state=%0d outs=%h want state=%0d outs=%h", i, state_o, outs, q_st[i], q_o[i]);
        bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    do_reset();
    start = 1'b1;
    ir_opcode = 6'h02;
    clear_q();
    add(0, O_Z, 3'b000); add(1, O_FETCH, 3'b000);
    add(2, mk(0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0), 3'b000);
    add(1, O_FETCH, 3'b000);
    for (int i = 0; i < q_st.size(); i++) begin
      {mem_ready, alu_zero, alu_ovf} = q_in[i];
      #1;
      total++;
      if (state_o !== q_st[i] || outs !== q_o[i]) begin
        $display("FAIL jump[%0d]: state=%0d outs=%h want state=%0d outs=%h", i, state_o, outs, q_st[i], q_o[i]);
        bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_timeout();
    do_reset();
    start = 1'b1;
    ir_opcode = 6'h2B;
    clear_q();
    add(0, O_Z, 3'b000); add(1, O_FETCH, 3'b000); add(2, O_Z, 3'b000); add(3, O_IMM, 3'b000);
    for (int k = 0; k < 15; k++) add(4, O_WR, 3'b000);
    add(6, mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 5'd5, 0), 3'b000);
    add(7, O_HALT, 3'b100); add(7, O_HALT, 3'b000);
    for (int i = 0; i < q_st.size(); i++) begin
      {mem_ready, alu_zero, alu_ovf} = q_in[i];
      #1;
      total++;
      if (state_o !== q_st[i] || outs !== q_o[i]) begin
        $display("FAIL sw_timeout[%0d]: state=%0d outs=%h want state=%0d outs=%h", i, state_o, outs, q_st[i], q_o[i]);
        bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exceptions();
    do_reset();
    start = 1'b1;
    ir_opcode = 6'h11;
    clear_q();
    add(0, O_Z, 3'b000); add(1, O_FETCH, 3'b000); add(2, O_Z, 3'b000);
    add(6, mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 5'd10, 0), 3'b000);
    add(7, O_HALT, 3'b000);
    for (int i = 0; i < q_st.size(); i++) begin
      {mem_ready, alu_zero, alu_ovf} = q_in[i];
      #1;
      total++;
      if (state_o !== q_st[i] || outs !== q_o[i]) begin
        $display("FAIL reserved_op[%0d]: state=%0d outs=%h want state=%0d outs=%h", i, state_o, outs, q_st[i], q_o[i]);
        bad++;
      end
      @(posedge clk); #1;
    end
    do_reset();
    start = 1'b1;
    ir_opcode = 6'h00;
    clear_q();
    add(0, O_Z, 3'b000); add(1, O_FETCH, 3'b000); add(2, O_Z, 3'b000);
    add(3, O_Z, 3'b001);
    add(6, mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 5'd12, 0), 3'b000);
    add(7, O_HALT, 3'b000);
    for (int i = 0; i < q_st.size(); i++) begin
      {mem_ready, alu_zero, alu_ovf} = q_in[i];
      #1;
      total++;
      if (state_o !== q_st[i] || outs !== q_o[i]) begin
        $display("FAIL overflow[%0d]: state=%0d outs=%h want state=%0d outs=%h", i, state_o, outs, q_st[i], q_o[i]);
        bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    do_reset();
    start = 1'b1;
    ir_opcode = 6'h3F;
    clear_q();
    add(0, O_Z, 3'b000); add(1, O_FETCH, 3'b000); add(2, O_Z, 3'b000);
    for (int i = 0; i < q_st.size(); i++) begin
      {mem_ready, alu_zero, alu_ovf} = q_in[i];
      #1;
      total++;
      if (state_o !== q_st[i] || outs !== q_o[i]) begin
        $display("FAIL halt_seq[%0d]: state=%0d outs=%h want state=%0d outs=%h", i, state_o, outs, q_st[i], q_o[i]);
        bad++;
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      #1;
      total++;
      if (state_o !== 3'd7 || outs !== O_HALT) begin
        $display("FAIL halt_sticky[%0d]: state=%0d outs=%h want state=7 outs=%h", i, state_o, outs, O_HALT);
        bad++;
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (state_o !== 3'd0 || signal !== 1'b0) begin
      $display("FAIL halt_reset: state=%0d signal=%b want state=0 signal=0", state_o, signal);
      bad++;
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    start = 1'b1;
    ir_opcode = 6'h23;
    clear_q();
    add(0, O_Z, 3'b000); add(1, O_FETCH, 3'b000); add(2, O_Z, 3'b000);
    add(3, O_IMM, 3'b000); add(4, O_RD, 3'b000);
    for (int i = 0; i < q_st.size(); i++) begin
      {mem_ready, alu_zero, alu_ovf} = q_in[i];
      #1;
      total++;
      if (state_o !== q_st[i] || outs !== q_o[i]) begin
        $display("FAIL mid_mem[%0d]: state=%0d outs=%h want state=%0d outs=%h", i, state_o, outs, q_st[i], q_o[i]);
        bad++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (mem_rd !== 1'b1) begin $display("FAIL mid_mem_rd_before: got %b want 1", mem_rd); bad++; end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (state_o !== 3'd0 || mem_rd !== 1'b0 || signal !== 1'b0 || outs !== O_Z) begin
      $display("FAIL mid_mem_reset: state=%0d mem_rd=%b signal=%b outs=%h want 0/0/0/%h",
               state_o, mem_rd, signal, outs, O_Z);
      bad++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_beq();
    test_jump();
    test_sw_timeout();
    test_exceptions();
    test_halt();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
